// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised LIFO stack: command encoding and
// modulo-DEPTH pointer helpers.
package stack_pkg;

    localparam int unsigned CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

    // Next slot above top, wrapping DEPTH-1 -> 0.
    function automatic int unsigned ptr_inc(input int unsigned top, input int unsigned depth);
        return (top == depth - 1) ? 0 : top + 1;
    endfunction

    // Slot below top, wrapping 0 -> DEPTH-1.
    function automatic int unsigned ptr_dec(input int unsigned top, input int unsigned depth);
        return (top == 0) ? depth - 1 : top - 1;
    endfunction

    // Slot n entries below top; n < depth, so one conditional add replaces the modulo.
    function automatic int unsigned ptr_sub(input int unsigned top, input int unsigned n,
                                            input int unsigned depth);
        return (top >= n) ? top - n : top + depth - n;
    endfunction

endpackage

// File: rtl/stack_ptr.sv
// Top-of-stack pointer and occupancy counter with registered flags.
// inc while full advances the pointer but saturates the count (wrap mode).
module stack_ptr
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    localparam int unsigned IW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [IW-1:0] top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [IW-1:0] top_nxt;
    logic [CW-1:0] count_nxt;

    // Next pointer and count from the inc/dec/hold control.
    always_comb begin
        top_nxt   = top;
        count_nxt = count;
        if (inc) begin
            top_nxt = IW'(ptr_inc(32'(top), DEPTH));
            if (count != CW'(DEPTH)) begin
                count_nxt = count + CW'(1);
            end
        end else if (dec) begin
            top_nxt   = IW'(ptr_dec(32'(top), DEPTH));
            count_nxt = count - CW'(1);
        end
    end

    // Pointer, count and flag registers; first push after reset lands in slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            top   <= IW'(DEPTH - 1);
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            top   <= top_nxt;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/stack_param.sv
// Parametrised command-driven LIFO stack with registered read data, valid and
// error strobes, occupancy flags and selectable overflow policy.
module stack_param
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 5,
    parameter bit          WRAP  = 1'b1,
    localparam int unsigned IW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       COMMAND,
    input  logic [IW-1:0]    INDEX,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             VALID_OUT,
    output logic             ERROR,
    output logic [CW-1:0]    COUNT,
    output logic             EMPTY,
    output logic             FULL
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    top;
    logic [IW-1:0]    push_addr;
    logic [IW-1:0]    rd_addr;
    logic             do_push;
    logic             do_pop;
    logic             do_read;
    logic             reject;

    stack_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk   (CLK),
        .reset (RESET),
        .inc   (do_push),
        .dec   (do_pop),
        .top   (top),
        .count (COUNT),
        .full  (FULL),
        .empty (EMPTY)
    );

    assign push_addr = IW'(ptr_inc(32'(top), DEPTH));

    // Command decode: qualify each command against occupancy and select read slot.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_read = 1'b0;
        reject  = 1'b0;
        rd_addr = top;
        case (cmd_e'(COMMAND))
            CMD_PUSH: begin
                if (!FULL || WRAP) do_push = 1'b1;
                else               reject  = 1'b1;
            end
            CMD_POP: begin
                if (!EMPTY) begin
                    do_pop  = 1'b1;
                    do_read = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
            CMD_GET: begin
                if (CW'(INDEX) < COUNT) begin
                    do_read = 1'b1;
                    rd_addr = IW'(ptr_sub(32'(top), 32'(INDEX), DEPTH));
                end else begin
                    reject = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Storage writes and registered read data / strobes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            DATA_OUT  <= '0;
            VALID_OUT <= 1'b0;
            ERROR     <= 1'b0;
        end else begin
            if (do_push) mem[push_addr] <= DATA_IN;
            if (do_read) DATA_OUT <= mem[rd_addr];
            VALID_OUT <= do_read;
            ERROR     <= reject;
        end
    end

endmodule

// File: tb/tb_stack_param.sv
// Directed self-checking bench: three stack instances (wrap D5, reject D5, wrap W8/D8).
module tb_stack_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4 DEPTH=5 WRAP=1
    logic       a_rst, a_vld, a_err, a_empty, a_full;
    logic [1:0] a_cmd;
    logic [2:0] a_idx, a_cnt;
    logic [3:0] a_din, a_dout;
    // Instance B: WIDTH=4 DEPTH=5 WRAP=0
    logic       b_rst, b_vld, b_err, b_empty, b_full;
    logic [1:0] b_cmd;
    logic [2:0] b_idx, b_cnt;
    logic [3:0] b_din, b_dout;
    // Instance C: WIDTH=8 DEPTH=8 WRAP=1
    logic       c_rst, c_vld, c_err, c_empty, c_full;
    logic [1:0] c_cmd;
    logic [2:0] c_idx;
    logic [3:0] c_cnt;
    logic [7:0] c_din, c_dout;

    stack_param #(.WIDTH(4), .DEPTH(5), .WRAP(1'b1)) u_a (
        .CLK(clk), .RESET(a_rst), .COMMAND(a_cmd), .INDEX(a_idx), .DATA_IN(a_din),
        .DATA_OUT(a_dout), .VALID_OUT(a_vld), .ERROR(a_err), .COUNT(a_cnt),
        .EMPTY(a_empty), .FULL(a_full));

    stack_param #(.WIDTH(4), .DEPTH(5), .WRAP(1'b0)) u_b (
        .CLK(clk), .RESET(b_rst), .COMMAND(b_cmd), .INDEX(b_idx), .DATA_IN(b_din),
        .DATA_OUT(b_dout), .VALID_OUT(b_vld), .ERROR(b_err), .COUNT(b_cnt),
        .EMPTY(b_empty), .FULL(b_full));

    stack_param #(.WIDTH(8), .DEPTH(8), .WRAP(1'b1)) u_c (
        .CLK(clk), .RESET(c_rst), .COMMAND(c_cmd), .INDEX(c_idx), .DATA_IN(c_din),
        .DATA_OUT(c_dout), .VALID_OUT(c_vld), .ERROR(c_err), .COUNT(c_cnt),
        .EMPTY(c_empty), .FULL(c_full));

    localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, GET = 2'b11;

    int n_checks = 0;
    int n_errors = 0;
    int cur = 0;

    logic [7:0] obs_data;
    logic [3:0] obs_count;
    logic       obs_vld, obs_err, obs_empty, obs_full;

    // Observe the instance currently under test.
    always_comb begin
        obs_data = '0; obs_count = '0; obs_vld = 1'b0; obs_err = 1'b0;
        obs_empty = 1'b0; obs_full = 1'b0;
        case (cur)
            0: begin
                obs_data = {4'h0, a_dout}; obs_count = {1'b0, a_cnt}; obs_vld = a_vld;
                obs_err = a_err; obs_empty = a_empty; obs_full = a_full;
            end
            1: begin
                obs_data = {4'h0, b_dout}; obs_count = {1'b0, b_cnt}; obs_vld = b_vld;
                obs_err = b_err; obs_empty = b_empty; obs_full = b_full;
            end
            default: begin
                obs_data = c_dout; obs_count = c_cnt; obs_vld = c_vld;
                obs_err = c_err; obs_empty = c_empty; obs_full = c_full;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one command to the selected instance, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic [1:0] cmd, input logic [7:0] din,
                        input logic [2:0] idx);
        a_rst = 1'b0; a_cmd = NOP; a_din = '0; a_idx = '0;
        b_rst = 1'b0; b_cmd = NOP; b_din = '0; b_idx = '0;
        c_rst = 1'b0; c_cmd = NOP; c_din = '0; c_idx = '0;
        case (cur)
            0:       begin a_rst = rst; a_cmd = cmd; a_din = din[3:0]; a_idx = idx; end
            1:       begin b_rst = rst; b_cmd = cmd; b_din = din[3:0]; b_idx = idx; end
            default: begin c_rst = rst; c_cmd = cmd; c_din = din;      c_idx = idx; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] data, input logic vld,
                              input logic err);
        check({tag, ".data"},  32'(obs_data), 32'(data));
        check({tag, ".valid"}, 32'(obs_vld),  32'(vld));
        check({tag, ".error"}, 32'(obs_err),  32'(err));
    endtask

    task automatic expect_occ(input string tag, input logic [3:0] cnt, input logic emp,
                              input logic ful);
        check({tag, ".count"}, 32'(obs_count), 32'(cnt));
        check({tag, ".empty"}, 32'(obs_empty), 32'(emp));
        check({tag, ".full"},  32'(obs_full),  32'(ful));
    endtask

    initial begin
        logic [7:0] exp_pop [5];
        exp_pop = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3};

        // ---------------- Instance A: WRAP=1, DEPTH=5 ----------------
        cur = 0;
        step(1'b1, NOP, 8'h0, 3'd0);
        expect_out("a_reset", 8'h0, 1'b0, 1'b0);
        expect_occ("a_reset", 4'd0, 1'b1, 1'b0);

        for (int i = 1; i <= 3; i++) step(1'b0, PUSH, 8'(i), 3'd0);
        expect_occ("a_push3", 4'd3, 1'b0, 1'b0);
        check("a_push3.valid", 32'(obs_vld), 32'd0);
        for (int i = 3; i >= 1; i--) begin
            step(1'b0, POP, 8'h0, 3'd0);
            expect_out($sformatf("a_pop%0d", i), 8'(i), 1'b1, 1'b0);
        end
        expect_occ("a_pop_empty", 4'd0, 1'b1, 1'b0);

        for (int i = 1; i <= 5; i++) step(1'b0, PUSH, 8'(i), 3'd0);
        expect_occ("a_fill", 4'd5, 1'b0, 1'b1);
        step(1'b0, GET, 8'h0, 3'd0); expect_out("a_get0", 8'd5, 1'b1, 1'b0);
        step(1'b0, GET, 8'h0, 3'd2); expect_out("a_get2", 8'd3, 1'b1, 1'b0);
        step(1'b0, GET, 8'h0, 3'd4); expect_out("a_get4", 8'd1, 1'b1, 1'b0);
        step(1'b0, GET, 8'h0, 3'd5); expect_out("a_get5", 8'd1, 1'b0, 1'b1);
        step(1'b0, NOP, 8'h0, 3'd0); expect_out("a_nop", 8'd1, 1'b0, 1'b0);
        expect_occ("a_get_hold", 4'd5, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b0, POP, 8'h0, 3'd0);
        step(1'b0, POP, 8'h0, 3'd0);
        expect_out("a_pop_on_empty", 8'd1, 1'b0, 1'b1);
        expect_occ("a_pop_on_empty", 4'd0, 1'b1, 1'b0);
        step(1'b0, GET, 8'h0, 3'd0);
        expect_out("a_get_on_empty", 8'd1, 1'b0, 1'b1);
        step(1'b0, PUSH, 8'd9, 3'd0);
        step(1'b0, POP, 8'h0, 3'd0);
        expect_out("a_push9_pop", 8'd9, 1'b1, 1'b0);

        for (int i = 1; i <= 7; i++) begin
            step(1'b0, PUSH, 8'(i), 3'd0);
            check($sformatf("a_wrap_push%0d.error", i), 32'(obs_err), 32'd0);
        end
        expect_occ("a_wrap", 4'd5, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, POP, 8'h0, 3'd0);
            expect_out($sformatf("a_wrap_pop%0d", i), exp_pop[i], 1'b1, 1'b0);
        end
        expect_occ("a_wrap_drained", 4'd0, 1'b1, 1'b0);

        step(1'b0, PUSH, 8'd1, 3'd0);
        step(1'b0, PUSH, 8'd2, 3'd0);
        step(1'b1, PUSH, 8'd7, 3'd0);
        expect_out("a_midreset", 8'd0, 1'b0, 1'b0);
        expect_occ("a_midreset", 4'd0, 1'b1, 1'b0);
        step(1'b0, POP, 8'h0, 3'd0);
        expect_out("a_pop_after_reset", 8'd0, 1'b0, 1'b1);

        // ---------------- Instance B: WRAP=0, DEPTH=5 ----------------
        cur = 1;
        step(1'b1, NOP, 8'h0, 3'd0);
        expect_occ("b_reset", 4'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, PUSH, 8'(i), 3'd0);
            check($sformatf("b_push%0d.error", i), 32'(obs_err), (i == 6) ? 32'd1 : 32'd0);
        end
        expect_occ("b_reject", 4'd5, 1'b0, 1'b1);
        step(1'b0, POP, 8'h0, 3'd0);
        expect_out("b_pop", 8'd5, 1'b1, 1'b0);
        expect_occ("b_pop", 4'd4, 1'b0, 1'b0);

        // ---------------- Instance C: WIDTH=8, DEPTH=8 ----------------
        cur = 2;
        step(1'b1, NOP, 8'h0, 3'd0);
        expect_occ("c_reset", 4'd0, 1'b1, 1'b0);
        step(1'b0, PUSH, 8'hA5, 3'd0);
        step(1'b0, POP, 8'h0, 3'd0);
        expect_out("c_pop_a5", 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, PUSH, 8'(8'h10 + i), 3'd0);
        expect_occ("c_fill", 4'd8, 1'b0, 1'b1);
        step(1'b0, GET, 8'h0, 3'd7);
        expect_out("c_get7", 8'h10, 1'b1, 1'b0);
        step(1'b0, GET, 8'h0, 3'd3);
        expect_out("c_get3", 8'h14, 1'b1, 1'b0);
        step(1'b1, PUSH, 8'h33, 3'd0);
        expect_out("c_midreset", 8'h00, 1'b0, 1'b0);
        expect_occ("c_midreset", 4'd0, 1'b1, 1'b0);

        step(1'b0, NOP, 8'h0, 3'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
